register_file_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/register_file_mp.sv | 112 +++++++++++
 tb/tb_register_file_mp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types, defaults and the flat-bus slicing helper for the multi-port register file.
package rf_pkg;

  typedef enum logic {RF_INIT, RF_READY} rf_state_e;

  localparam int RF_DEF_XLEN  = 64;
  localparam int RF_DEF_NREGS = 32;
  localparam int RF_MAX_BUS   = 1024;
  localparam int RF_MAX_W     = 64;

  // Returns field idx of width w from a zero-extended flat bus; callers truncate to w.
  function automatic logic [RF_MAX_W-1:0] rf_slice(input logic [RF_MAX_BUS-1:0] bus,
                                                   input int idx, input int w);
    return RF_MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared by writeback, set beats clear.
// rd_busy is combinational; state updates on the edge; no backpressure.
module rf_scoreboard import rf_pkg::*; #(
  parameter int NREGS  = RF_DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW-1:0]    ra;
  logic             hit;

  always_comb begin
    busy_d = busy_q;
    if (en) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) busy_d[AW'(rf_slice(RF_MAX_BUS'(wr_addr), j, AW))] = 1'b0;
      end
      if (sb_set_en) busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // A write landing this cycle resolves the hazard early when its data is forwarded.
  always_comb begin
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = AW'(rf_slice(RF_MAX_BUS'(rd_addr), i, AW));
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && AW'(rf_slice(RF_MAX_BUS'(wr_addr), j, AW)) == ra) hit = 1'b1;
        end
      end
      rd_busy[i] = en && busy_q[ra] && !hit;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write bypass, busy scoreboard and reset clearing sweep.
// Reads combinational, writes visible next edge; no backpressure, traffic ignored until init_done.
module register_file_mp import rf_pkg::*; #(
  parameter  int XLEN   = RF_DEF_XLEN,
  parameter  int NREGS  = RF_DEF_NREGS,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   wa [NUM_WR];
  logic [XLEN-1:0] wd [NUM_WR];
  logic [AW-1:0]   ra [NUM_RD];
  logic [XLEN-1:0] rdat;
  logic            ready;

  assign ready     = (state_q == RF_READY);
  assign init_done = ready;

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = AW'(rf_slice(RF_MAX_BUS'(wr_addr), j, AW));
      wd[j] = XLEN'(rf_slice(RF_MAX_BUS'(wr_data), j, XLEN));
    end
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = AW'(rf_slice(RF_MAX_BUS'(rd_addr), i, AW));
    end
  end

  // Later write ports override earlier ones, giving the highest index priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    if (state_q == RF_INIT) begin
      regs_d[cnt_q] = '0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) state_d = RF_READY;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wa[j] != '0) regs_d[wa[j]] = wd[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) regs_q <= regs_d;
  end

  always_comb begin
    rd_data = '0;
    rdat    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdat = '0;
      if (ready && ra[i] != '0) begin
        rdat = regs_q[ra[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wa[j] == ra[i]) rdat = wd[j];
          end
        end
      end
      rd_data[i*XLEN +: XLEN] = rdat;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .en          (ready),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rd_busy     (rd_busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Random and directed checks of register_file_mp against an array-based reference model,
// covering default, no-bypass and narrow/three-read configurations.
module tb_register_file_mp;

  localparam int AW  = 5;
  localparam int AWC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default (A, bypass) and no-bypass (B) instances share one stimulus set.
  logic             rst_ab = 1'b1;
  logic [2*AW-1:0]  rd_addr_ab = '0;
  logic [1:0]       wr_en_ab = '0;
  logic [2*AW-1:0]  wr_addr_ab = '0;
  logic [127:0]     wr_data_ab = '0;
  logic             sb_set_en_ab = 1'b0;
  logic [AW-1:0]    sb_set_addr_ab = '0;
  logic             init_done_a, init_done_b;
  logic [127:0]     rd_data_a, rd_data_b;
  logic [1:0]       rd_busy_a, rd_busy_b;

  logic             rst_c = 1'b1;
  logic [3*AWC-1:0] rd_addr_c = '0;
  logic [0:0]       wr_en_c = '0;
  logic [AWC-1:0]   wr_addr_c = '0;
  logic [31:0]      wr_data_c = '0;
  logic             sb_set_en_c = 1'b0;
  logic [AWC-1:0]   sb_set_addr_c = '0;
  logic             init_done_c;
  logic [95:0]      rd_data_c;
  logic [2:0]       rd_busy_c;

  register_file_mp u_dut_a (
    .clk(clk), .rst(rst_ab), .init_done(init_done_a), .rd_addr(rd_addr_ab), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab),
    .sb_set_en(sb_set_en_ab), .sb_set_addr(sb_set_addr_ab));

  register_file_mp #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst_ab), .init_done(init_done_b), .rd_addr(rd_addr_ab), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab),
    .sb_set_en(sb_set_en_ab), .sb_set_addr(sb_set_addr_ab));

  register_file_mp #(.XLEN(32), .NREGS(16), .NUM_RD(3), .NUM_WR(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .init_done(init_done_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .rd_busy(rd_busy_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .sb_set_en(sb_set_en_c), .sb_set_addr(sb_set_addr_c));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Abstract stimulus for the configuration under test.
  int          cur = 0;
  int          nregs = 32, nrd = 2, nwr = 2;
  logic [63:0] xmask = '1;
  bit          s_rst;
  int          s_ra [3];
  bit          s_we [2];
  int          s_wa [2];
  logic [63:0] s_wd [2];
  bit          s_sbe;
  int          s_sba;

  // Reference model.
  bit          m_known = 0, m_ready = 0;
  int          m_left = 0;
  logic [63:0] m_mem [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] exp_rd(input int i, input bit byp);
    logic [63:0] r;
    int a;
    a = s_ra[i];
    if (!m_ready || a == 0) return '0;
    r = m_mem[a];
    if (byp) for (int j = 0; j < nwr; j++) if (s_we[j] && s_wa[j] == a) r = s_wd[j] & xmask;
    return r;
  endfunction

  function automatic bit exp_busy(input int i, input bit byp);
    bit b;
    if (!m_ready) return 1'b0;
    b = m_busy[s_ra[i]];
    if (byp) for (int j = 0; j < nwr; j++) if (s_we[j] && s_wa[j] == s_ra[i]) b = 1'b0;
    return b;
  endfunction

  task automatic idle();
    s_rst = 0; s_sbe = 0; s_sba = 0;
    for (int i = 0; i < 3; i++) s_ra[i] = 0;
    for (int j = 0; j < 2; j++) begin s_we[j] = 0; s_wa[j] = 0; s_wd[j] = '0; end
  endtask

  task automatic rand_inputs(input bit allow_rst);
    s_rst = allow_rst && ($urandom_range(0, 299) == 0);
    for (int j = 0; j < nwr; j++) begin
      s_we[j] = 1'($urandom_range(0, 1));
      s_wa[j] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, nregs - 1));
      s_wd[j] = {$urandom, $urandom};
    end
    for (int i = 0; i < nrd; i++)
      s_ra[i] = ($urandom_range(0, 2) == 0) ? s_wa[0] : int'($urandom_range(0, nregs - 1));
    s_sbe = 1'($urandom_range(0, 1));
    s_sba = int'($urandom_range(0, nregs - 1));
  endtask

  task automatic apply();
    if (cur == 0) begin
      rst_ab = s_rst; sb_set_en_ab = s_sbe; sb_set_addr_ab = AW'(s_sba);
      for (int i = 0; i < 2; i++) begin
        rd_addr_ab[i*AW +: AW]  = AW'(s_ra[i]);
        wr_en_ab[i]             = s_we[i];
        wr_addr_ab[i*AW +: AW]  = AW'(s_wa[i]);
        wr_data_ab[i*64 +: 64]  = s_wd[i];
      end
    end else begin
      rst_c = s_rst; sb_set_en_c = s_sbe; sb_set_addr_c = AWC'(s_sba);
      for (int i = 0; i < 3; i++) rd_addr_c[i*AWC +: AWC] = AWC'(s_ra[i]);
      wr_en_c[0] = s_we[0];
      wr_addr_c  = AWC'(s_wa[0]);
      wr_data_c  = s_wd[0][31:0];
    end
  endtask

  task automatic check_outputs();
    if (cur == 0) begin
      chk("init_done_a", 64'(init_done_a), 64'(m_ready));
      chk("init_done_b", 64'(init_done_b), 64'(m_ready));
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rd_data_a[%0d]", i), rd_data_a[i*64 +: 64], exp_rd(i, 1));
        chk($sformatf("rd_data_b[%0d]", i), rd_data_b[i*64 +: 64], exp_rd(i, 0));
        chk($sformatf("rd_busy_a[%0d]", i), 64'(rd_busy_a[i]), 64'(exp_busy(i, 1)));
        chk($sformatf("rd_busy_b[%0d]", i), 64'(rd_busy_b[i]), 64'(exp_busy(i, 0)));
      end
    end else begin
      chk("init_done_c", 64'(init_done_c), 64'(m_ready));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rd_data_c[%0d]", i), 64'(rd_data_c[i*32 +: 32]), exp_rd(i, 1));
        chk($sformatf("rd_busy_c[%0d]", i), 64'(rd_busy_c[i]), 64'(exp_busy(i, 1)));
      end
    end
  endtask

  task automatic drive_check();
    @(negedge clk);
    apply();
    #1;
    if (m_known) check_outputs();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (s_rst) begin
      m_known = 1; m_ready = 0; m_left = nregs;
      for (int k = 0; k < 32; k++) m_busy[k] = 0;
    end else if (m_known && !m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
      end
    end else if (m_ready) begin
      for (int j = 0; j < nwr; j++) if (s_we[j] && s_wa[j] != 0) m_mem[s_wa[j]] = s_wd[j] & xmask;
      for (int j = 0; j < nwr; j++) if (s_we[j]) m_busy[s_wa[j]] = 0;
      if (s_sbe && s_sba != 0) m_busy[s_sba] = 1;
    end
  endtask

  task automatic cycle();
    drive_check();
    clk_edge();
  endtask

  task automatic reset_and_sweep(input int pre_done);
    idle(); s_rst = 1; cycle();
    for (int k = 0; k < pre_done; k++) begin rand_inputs(0); cycle(); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin m_mem[k] = '0; m_busy[k] = 0; end
    idle();

    // Sweep with write traffic held on: nothing taken, init_done on edge NREGS.
    reset_and_sweep(31);
    #2 chk("init_before_edge32", 64'(init_done_a), 64'd0);
    rand_inputs(0); cycle();
    #2 chk("init_at_edge32", 64'(init_done_a), 64'd1);
    for (int k = 0; k < 40; k++) begin rand_inputs(0); cycle(); end

    // Dual-write conflict and x0 write.
    idle(); s_we[0] = 1; s_we[1] = 1; s_wa[0] = 5; s_wa[1] = 5; s_wd[0] = 64'h11; s_wd[1] = 64'h22; cycle();
    idle(); s_ra[0] = 5; drive_check(); chk("dual_wr_hi_port", rd_data_a[63:0], 64'h22); clk_edge();
    idle(); s_we[0] = 1; s_wa[0] = 0; s_wd[0] = 64'hFF; drive_check();
    chk("x0_same_cycle", rd_data_a[63:0], 64'h0); clk_edge();
    idle(); drive_check(); chk("x0_after", rd_data_a[63:0], 64'h0); clk_edge();

    // Bypass versus stored-only read of x7.
    idle(); s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 64'h1234; cycle();
    idle(); s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 64'hABCD; s_ra[1] = 7; drive_check();
    chk("bypass_same_cycle", rd_data_a[127:64], 64'hABCD);
    chk("nobypass_same_cycle", rd_data_b[127:64], 64'h1234); clk_edge();
    idle(); s_ra[1] = 7; drive_check(); chk("nobypass_next", rd_data_b[127:64], 64'hABCD); clk_edge();

    // Scoreboard set, bypass mask, clear, and set-beats-clear.
    idle(); s_sbe = 1; s_sba = 9; cycle();
    idle(); s_ra[0] = 9; drive_check(); chk("busy_set", 64'(rd_busy_a[0]), 64'd1); clk_edge();
    idle(); s_ra[0] = 9; s_we[0] = 1; s_wa[0] = 9; s_wd[0] = 64'h5; drive_check();
    chk("busy_bypass_mask", 64'(rd_busy_a[0]), 64'd0);
    chk("busy_nobypass", 64'(rd_busy_b[0]), 64'd1); clk_edge();
    idle(); s_ra[0] = 9; drive_check(); chk("busy_cleared", 64'(rd_busy_a[0]), 64'd0); clk_edge();
    idle(); s_sbe = 1; s_sba = 9; s_we[1] = 1; s_wa[1] = 9; s_wd[1] = 64'h6; cycle();
    idle(); s_ra[0] = 9; drive_check(); chk("busy_set_wins", 64'(rd_busy_a[0]), 64'd1); clk_edge();

    // Mid-sweep reset after prior 0xDEAD contents.
    idle(); s_we[0] = 1; s_wa[0] = 1; s_wd[0] = 64'hDEAD; cycle();
    idle(); s_ra[0] = 1; drive_check(); chk("dead_written", rd_data_a[63:0], 64'hDEAD); clk_edge();
    reset_and_sweep(10);
    reset_and_sweep(31);
    #2 chk("midsweep_init_late", 64'(init_done_a), 64'd0);
    rand_inputs(0); cycle();
    #2 chk("midsweep_init_done", 64'(init_done_a), 64'd1);
    idle(); s_ra[0] = 1; drive_check(); chk("dead_cleared", rd_data_a[63:0], 64'h0); clk_edge();

    for (int k = 0; k < 600; k++) begin rand_inputs(1); cycle(); end

    // Narrow configuration: XLEN=32, NREGS=16, three reads, one write.
    cur = 1; nregs = 16; nrd = 3; nwr = 1; xmask = 64'h0000_0000_FFFF_FFFF;
    m_known = 0; m_ready = 0;
    reset_and_sweep(15);
    #2 chk("c_init_before", 64'(init_done_c), 64'd0);
    rand_inputs(0); cycle();
    #2 chk("c_init_done", 64'(init_done_c), 64'd1);
    idle(); s_we[0] = 1; s_wa[0] = 3; s_wd[0] = 64'h1_0000_5A5A; cycle();
    idle(); s_ra[0] = 3; s_ra[1] = 3; s_ra[2] = 3; drive_check();
    for (int i = 0; i < 3; i++) chk($sformatf("c_same_addr[%0d]", i), 64'(rd_data_c[i*32 +: 32]), 64'h5A5A);
    clk_edge();
    for (int k = 0; k < 600; k++) begin rand_inputs(1); cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
